// File: rtl/k16_mem_responder_pkg.sv
// k16_mem_responder_pkg: shared bus definitions for the K16 memory responder.
// Return-source tags, the default I/O page base and a page-match helper.
package k16_mem_responder_pkg;

  // Where the data arriving next cycle should be routed.
  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_CPU  = 2'd1,
    RET_VGA  = 2'd2,
    RET_IO   = 2'd3
  } ret_tag_t;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
  localparam int unsigned IO_REG_AW       = 3;

  // True when an address page (upper byte) matches the I/O page.
  function automatic logic is_io_page(input logic [7:0] page, input logic [7:0] base_page);
    return (page == base_page);
  endfunction

endpackage

// File: rtl/k16_mem_responder_if.sv
// k16_mem_responder_if: CPU bus, VGA fetch port and RAM port of the responder.
// master = CPU/VGA/RAM side (the environment), slave = the responder.
interface k16_mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              busy;
  logic [ADDR_W-1:0] address;
  logic [15:0]       data_out;
  logic              write;
  logic              hold;
  logic [15:0]       data_in;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic [15:0]       vga_data;

  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic              ram_we;
  logic [15:0]       ram_rdata;

  modport slave (
    input  busy, address, data_out, write, vga_req, vga_addr, ram_rdata,
    output hold, data_in, vga_ack, vga_data, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output busy, address, data_out, write, vga_req, vga_addr, ram_rdata,
    input  hold, data_in, vga_ack, vga_data, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/k16_mem_responder_io_regs.sv
// k16_io_regs: 8 x 16 I/O register file, synchronous write, registered read.
// Only instantiated when K16_IO_PAGE_EN is defined.
module k16_io_regs (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic        i_re,
  input  logic [2:0]  i_raddr,
  output logic [15:0] o_rdata
);
  logic [15:0] r_regs [0:7];
  logic [15:0] r_rdata;

  // Register file storage: cleared on reset, written on accepted I/O writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port: data appears the cycle after the read is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= 16'h0000;
    end else if (i_re) begin
      r_rdata <= r_regs[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/k16_mem_responder.sv
// k16_mem_responder: shares one synchronous RAM port between the K16 CPU bus
// and the VGA pixel fetcher. VGA normally wins a conflict, but a CPU that was
// stalled last cycle wins this one, so neither side waits more than 1 cycle.
// Optional feature macro: K16_IO_PAGE_EN (8 mirrored I/O registers on the
// IO_BASE page, accessed without touching the RAM port).
module k16_mem_responder
  import k16_mem_responder_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input logic                      clk,
  input logic                      reset_n,
  k16_mem_responder_if.slave       bus
);
  logic              r_cpu_starved;
  ret_tag_t          r_cpu_ret;
  ret_tag_t          r_vga_ret;
  logic [15:0]       r_data_in;
  logic [15:0]       r_vga_data;

  logic              w_io_hit;
  logic              w_cpu_needs_ram;
  logic              w_grant_vga;
  logic              w_hold;
  logic              w_cpu_accept;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  ret_tag_t          w_cpu_ret_nxt;
  ret_tag_t          w_vga_ret_nxt;
  logic [15:0]       w_data_in;
  logic [15:0]       w_vga_data;

`ifdef K16_IO_PAGE_EN
  logic [15:0]       w_io_rdata;

  assign w_io_hit = bus.busy & is_io_page(bus.address[ADDR_W-1 -: 8], IO_BASE[ADDR_W-1 -: 8]);

  // I/O accesses never stall, so busy alone means accepted.
  k16_io_regs u_io_regs (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_we    (w_io_hit & bus.write),
    .i_waddr (bus.address[IO_REG_AW-1:0]),
    .i_wdata (bus.data_out),
    .i_re    (w_io_hit & ~bus.write),
    .i_raddr (bus.address[IO_REG_AW-1:0]),
    .o_rdata (w_io_rdata)
  );
`else
  logic              w_unused_io_base;

  assign w_io_hit         = 1'b0;
  assign w_unused_io_base = ^IO_BASE;
`endif

  // Arbitration: a starved CPU that needs the RAM blocks VGA for one cycle.
  assign w_cpu_needs_ram = bus.busy & ~w_io_hit;
  assign w_grant_vga     = bus.vga_req & ~(bus.busy & r_cpu_starved & w_cpu_needs_ram);
  assign w_hold          = reset_n & bus.busy & w_cpu_needs_ram & w_grant_vga;
  assign w_cpu_accept    = bus.busy & ~w_hold;

  // RAM port mux; writes are suppressed in reset so an in-flight access aborts.
  always_comb begin
    w_ram_addr = bus.address;
    w_ram_we   = 1'b0;
    if (w_grant_vga) begin
      w_ram_addr = bus.vga_addr;
      w_ram_we   = 1'b0;
    end else begin
      w_ram_addr = bus.address;
      w_ram_we   = reset_n & w_cpu_accept & bus.write & w_cpu_needs_ram;
    end
  end

  // Return tags for data arriving next cycle (CPU and VGA can return together).
  always_comb begin
    w_cpu_ret_nxt = RET_NONE;
    w_vga_ret_nxt = RET_NONE;
    if (w_cpu_accept & ~bus.write) begin
      w_cpu_ret_nxt = w_io_hit ? RET_IO : RET_CPU;
    end else begin
      w_cpu_ret_nxt = RET_NONE;
    end
    if (w_grant_vga) begin
      w_vga_ret_nxt = RET_VGA;
    end else begin
      w_vga_ret_nxt = RET_NONE;
    end
  end

  // CPU read data: pass returning data through, otherwise hold the last read.
  always_comb begin
    w_data_in = r_data_in;
    case (r_cpu_ret)
      RET_CPU: w_data_in = bus.ram_rdata;
`ifdef K16_IO_PAGE_EN
      RET_IO:  w_data_in = w_io_rdata;
`endif
      default: w_data_in = r_data_in;
    endcase
  end

  // VGA read data: valid alongside vga_ack, held afterwards.
  always_comb begin
    if (r_vga_ret == RET_VGA) begin
      w_vga_data = bus.ram_rdata;
    end else begin
      w_vga_data = r_vga_data;
    end
  end

  // Arbitration history, return tags and held read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_starved <= 1'b0;
      r_cpu_ret     <= RET_NONE;
      r_vga_ret     <= RET_NONE;
      r_data_in     <= 16'h0000;
      r_vga_data    <= 16'h0000;
    end else begin
      r_cpu_starved <= w_hold;
      r_cpu_ret     <= w_cpu_ret_nxt;
      r_vga_ret     <= w_vga_ret_nxt;
      r_data_in     <= w_data_in;
      r_vga_data    <= w_vga_data;
    end
  end

  assign bus.hold      = w_hold;
  assign bus.data_in   = w_data_in;
  assign bus.vga_ack   = (r_vga_ret == RET_VGA);
  assign bus.vga_data  = w_vga_data;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = bus.data_out;
  assign bus.ram_we    = w_ram_we;
endmodule

// File: tb/tb_k16_mem_responder.sv
// Testbench for k16_mem_responder: directed scenarios plus randomized CPU/VGA
// traffic, checked against a cycle-level reference of the bus rules.
module tb_k16_mem_responder;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  k16_mem_responder_if #(.ADDR_W(16)) bus ();

  k16_mem_responder #(.ADDR_W(16), .IO_BASE(16'hFF00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous single-port RAM, read-first, one cycle read latency.
  logic [15:0] ram_mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  // Reference state.
  logic [15:0] m_mem [0:65535];
  logic [15:0] m_io  [0:7];
  bit          m_starved, m_cpu_pend, m_vga_pend, m_prev_hold_obs;
  logic [15:0] m_cpu_val, m_vga_val, m_data_in, m_vga_data;
  logic [15:0] pool [0:7];
  int          checks = 0;
  int          failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_io(input logic [15:0] a);
`ifdef K16_IO_PAGE_EN
    return (a[15:8] == 8'hFF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] pick();
    int unsigned k;
    k = $urandom_range(0, 8);
    if (k == 8) return 16'($urandom);
    return pool[k];
  endfunction

  task automatic model_reset();
    m_starved = 0; m_cpu_pend = 0; m_vga_pend = 0; m_prev_hold_obs = 0;
    m_data_in = 16'h0000; m_vga_data = 16'h0000;
    for (int i = 0; i < 8; i++) m_io[i] = 16'h0000;
  endtask

  // One bus cycle; entered 1 time unit after a rising edge, returns likewise.
  task automatic cycle(input bit busy, input bit wr, input logic [15:0] addr,
                       input logic [15:0] dout, input bit vreq, input logic [15:0] vaddr,
                       output bit hold_e, output bit grant_e);
    bit needs, accept;
    if (m_cpu_pend) m_data_in = m_cpu_val;
    if (m_vga_pend) m_vga_data = m_vga_val;
    bus.busy = busy; bus.write = wr; bus.address = addr; bus.data_out = dout;
    bus.vga_req = vreq; bus.vga_addr = vaddr;
    #3;
    needs   = busy && !is_io(addr);
    grant_e = vreq && !(needs && m_starved);
    hold_e  = needs && grant_e;
    accept  = busy && !hold_e;
    chk_eq("hold", bus.hold, hold_e);
    chk_eq("ram_we", bus.ram_we, accept && wr && needs);
    if (grant_e) chk_eq("ram_addr_vga", bus.ram_addr, vaddr);
    else if (needs) chk_eq("ram_addr_cpu", bus.ram_addr, addr);
    if (accept && wr && needs) chk_eq("ram_wdata", bus.ram_wdata, dout);
    chk_eq("vga_ack", bus.vga_ack, m_vga_pend);
    if (m_vga_pend) chk_eq("vga_data", bus.vga_data, m_vga_data);
    chk_eq("data_in", bus.data_in, m_data_in);
    chk_eq("hold_run", bus.hold && m_prev_hold_obs, 1'b0);
    m_prev_hold_obs = bus.hold;
    m_vga_pend = grant_e;
    if (grant_e) m_vga_val = m_mem[vaddr];
    m_cpu_pend = accept && !wr;
    if (m_cpu_pend) m_cpu_val = is_io(addr) ? m_io[addr[2:0]] : m_mem[addr];
    if (accept && wr) begin
      if (is_io(addr)) m_io[addr[2:0]] = dout;
      else m_mem[addr] = dout;
    end
    m_starved = hold_e;
    @(posedge clk); #1;
  endtask

  bit          h, g, c_busy, c_wr, v_req;
  logic [15:0] c_addr, c_dout, v_addr;

  initial begin
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0002; pool[3] = 16'h1000;
    pool[4] = 16'hFFFF; pool[5] = 16'hFF03; pool[6] = 16'hFF0B; pool[7] = 16'hFE10;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 16'(i) ^ 16'hA5C3;
      m_mem[i]   = 16'(i) ^ 16'hA5C3;
    end
    model_reset();
    // In reset with a write and a VGA request pending: nothing may happen.
    reset_n = 1'b0;
    bus.busy = 1'b1; bus.write = 1'b1; bus.address = 16'h0003; bus.data_out = 16'hDEAD;
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0004;
    #3;
    chk_eq("rst_hold", bus.hold, 1'b0);
    chk_eq("rst_we", bus.ram_we, 1'b0);
    chk_eq("rst_data_in", bus.data_in, 16'h0000);
    chk_eq("rst_vga_ack", bus.vga_ack, 1'b0);
    chk_eq("rst_vga_data", bus.vga_data, 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // CPU only: write then read back with no wait states.
    cycle(1, 1, 16'h0000, 16'h6257, 0, 16'h0000, h, g);
    cycle(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);
    chk_eq("cpu_rd_6257", bus.data_in, 16'h6257);
    cycle(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);

    // Collision: VGA wins first, CPU accepted next cycle despite vga_req high.
    cycle(1, 1, 16'h0001, 16'h0480, 0, 16'h0000, h, g);
    cycle(1, 1, 16'h1000, 16'h1234, 0, 16'h0000, h, g);
    cycle(1, 0, 16'h0001, 16'h0000, 1, 16'h1000, h, g);
    chk_eq("coll_vga_data", bus.vga_data, 16'h1234);
    chk_eq("coll_vga_ack", bus.vga_ack, 1'b1);
    cycle(1, 0, 16'h0001, 16'h0000, 1, 16'h2001, h, g);
    chk_eq("coll_cpu_data", bus.data_in, 16'h0480);
    cycle(0, 0, 16'h0000, 16'h0000, 1, 16'h2001, h, g);
    cycle(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);

    // Starvation guard: continuous CPU reads against a continuous VGA stream.
    h = 0; v_addr = 16'h3000; c_addr = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      if (!h) c_addr = pick();
      cycle(1, 0, c_addr, 16'h0000, 1, v_addr, h, g);
      if (g) v_addr = v_addr + 16'd1;
    end
    cycle(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);

    // Wrap at the top of the address space.
    cycle(1, 1, 16'hFFFF, 16'h7E57, 0, 16'h0000, h, g);
    cycle(1, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, h, g);
    chk_eq("wrap_ffff", bus.data_in, 16'h7E57);
    cycle(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);
    chk_eq("wrap_0000", bus.data_in, 16'h6257);
    cycle(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);

`ifdef K16_IO_PAGE_EN
    // I/O write in parallel with a VGA fetch, then read back through a mirror.
    cycle(1, 1, 16'hFF03, 16'hABCD, 1, 16'h3000, h, g);
    chk_eq("io_vga_ack", bus.vga_ack, 1'b1);
    cycle(1, 0, 16'hFF0B, 16'h0000, 0, 16'h0000, h, g);
    chk_eq("io_mirror", bus.data_in, 16'hABCD);
    cycle(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);
`endif

    // Reset asserted mid-write: the write must be aborted immediately.
    bus.busy = 1'b1; bus.write = 1'b1; bus.address = 16'h0002; bus.data_out = 16'hBEEF;
    bus.vga_req = 1'b0; bus.vga_addr = 16'h0000;
    #1;
    chk_eq("pre_rst_we", bus.ram_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_eq("midrst_we", bus.ram_we, 1'b0);
    chk_eq("midrst_hold", bus.hold, 1'b0);
    chk_eq("midrst_data_in", bus.data_in, 16'h0000);
    chk_eq("midrst_vga_ack", bus.vga_ack, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    cycle(1, 0, 16'h0002, 16'h0000, 0, 16'h0000, h, g);
    chk_eq("aborted_write", bus.data_in, 16'h0002 ^ 16'hA5C3);

    // Randomized traffic obeying the CPU retry and VGA fetch protocols.
    h = 0; g = 0; v_req = 0; c_busy = 0; c_wr = 0; c_addr = 16'h0000; c_dout = 16'h0000;
    v_addr = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      if (!h) begin
        c_busy = ($urandom_range(0, 3) != 0);
        c_wr   = ($urandom_range(0, 2) == 0);
        c_addr = pick();
        c_dout = 16'($urandom);
      end
      if (g || !v_req) begin
        v_req  = ($urandom_range(0, 1) == 1);
        v_addr = pick();
      end
      cycle(c_busy, c_wr, c_addr, c_dout, v_req, v_addr, h, g);
    end
    cycle(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, h, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
